// File: rtl/dp_exec_core.sv
// dp_exec_core: MiniSRC execution datapath with register file, operand
// latches, single-cycle ALU, iterative signed MUL/DIV into HI/LO and an
// IDLE -> READ -> EXEC -> WB micro-sequencer behind a request handshake.
module dp_exec_core #(
  parameter int WIDTH   = 32,
  parameter int NREGS   = 16,
  parameter bit ZERO_R0 = 1'b1
) (
  input  logic                     iClk,
  input  logic                     nRst,
  input  logic                     iReq_valid,
  output logic                     oReq_ready,
  input  logic [3:0]               iOp,
  input  logic [$clog2(NREGS)-1:0] iRa,
  input  logic [$clog2(NREGS)-1:0] iRb,
  input  logic [$clog2(NREGS)-1:0] iRc,
  input  logic                     iImmSel,
  input  logic [WIDTH-1:0]         iImm,
  output logic                     oDone,
  output logic                     oZero,
  output logic                     oNeg,
  output logic                     oDivZero,
  input  logic [$clog2(NREGS)-1:0] iDbg_addr,
  output logic [WIDTH-1:0]         oDbg_data,
  output logic [1:0]               oDbg_state
);

  localparam int AW = $clog2(NREGS);
  localparam int SW = $clog2(WIDTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_READ = 2'd1;
  localparam logic [1:0] S_EXEC = 2'd2;
  localparam logic [1:0] S_WB   = 2'd3;

  localparam logic [3:0] OP_MUL = 4'h9;
  localparam logic [3:0] OP_DIV = 4'hA;
  localparam logic [3:0] OP_NOP = 4'hF;

  // Request handshake: a request transfers on a rising edge where iReq_valid
  // and oReq_ready are both 1. oReq_ready is 1 only in IDLE once the first
  // edge after reset release has passed; op fields are captured only on the
  // transfer edge and are ignored at all other times.

  logic [1:0]       state_q, state_d;
  logic             live_q;
  logic [3:0]       op_q;
  logic [AW-1:0]    ra_q, rb_q, rc_q;
  logic             immsel_q;
  logic [WIDTH-1:0] imm_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [WIDTH-1:0] wk_hi_q, wk_lo_q, mag_q;
  logic [SW-1:0]    cnt_q;
  logic [WIDTH-1:0] hi_q, lo_q;
  logic             zero_q, neg_q, dz_q;
  logic [WIDTH-1:0] rf_q [NREGS];

  logic             accept, is_long;
  logic [WIDTH-1:0] opa, opb;
  logic [WIDTH:0]   mul_sum, div_rs;
  logic             div_ge;
  logic [WIDTH-1:0] div_diff;
  logic [SW-1:0]    sh;
  logic [WIDTH-1:0] alu;
  logic [2*WIDTH-1:0] prod_mag, prod;
  logic [WIDTH-1:0] quot, rem, div_lo, div_hi;
  logic             div_zero;

  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? -v : v;
  endfunction

  assign oReq_ready = live_q && (state_q == S_IDLE);
  assign accept     = iReq_valid && oReq_ready;
  assign is_long    = (op_q == OP_MUL) || (op_q == OP_DIV);
  assign oDone      = (state_q == S_WB);
  assign oZero      = zero_q;
  assign oNeg       = neg_q;
  assign oDivZero   = dz_q;
  assign oDbg_state = state_q;
  assign oDbg_data  = (ZERO_R0 && (iDbg_addr == '0)) ? '0 : rf_q[iDbg_addr];

  assign opa = (ZERO_R0 && (ra_q == '0)) ? '0 : rf_q[ra_q];
  assign opb = immsel_q ? imm_q : ((ZERO_R0 && (rb_q == '0)) ? '0 : rf_q[rb_q]);

  // Sequencer next state: multi-cycle ops stay in EXEC for WIDTH cycles.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_READ;
      S_READ:  state_d = S_EXEC;
      S_EXEC:  if (!is_long || (cnt_q == SW'(WIDTH - 1))) state_d = S_WB;
      default: state_d = S_IDLE;
    endcase
  end

  // One iteration of shift-add multiply and restoring divide on magnitudes.
  always_comb begin
    mul_sum  = {1'b0, wk_hi_q} + (wk_lo_q[0] ? {1'b0, mag_q} : '0);
    div_rs   = {wk_hi_q, wk_lo_q[WIDTH-1]};
    div_ge   = (div_rs >= {1'b0, mag_q});
    div_diff = div_rs[WIDTH-1:0] - mag_q;
  end

  // Writeback values: ALU result, signed product and signed quotient/remainder.
  always_comb begin
    sh = b_q[SW-1:0];
    case (op_q)
      4'h0:    alu = a_q + b_q;
      4'h1:    alu = a_q - b_q;
      4'h2:    alu = a_q & b_q;
      4'h3:    alu = a_q | b_q;
      4'h4:    alu = a_q >> sh;
      4'h5:    alu = $signed(a_q) >>> sh;
      4'h6:    alu = a_q << sh;
      4'h7:    alu = (a_q >> sh) | (a_q << (WIDTH - int'(sh)));
      4'h8:    alu = (a_q << sh) | (a_q >> (WIDTH - int'(sh)));
      4'hB:    alu = -a_q;
      4'hC:    alu = ~a_q;
      4'hD:    alu = hi_q;
      4'hE:    alu = lo_q;
      default: alu = '0;
    endcase
    prod_mag = {wk_hi_q, wk_lo_q};
    prod     = (a_q[WIDTH-1] ^ b_q[WIDTH-1]) ? -prod_mag : prod_mag;
    quot     = (a_q[WIDTH-1] ^ b_q[WIDTH-1]) ? -wk_lo_q : wk_lo_q;
    rem      = a_q[WIDTH-1] ? -wk_hi_q : wk_hi_q;
    div_zero = (b_q == '0);
    div_lo   = div_zero ? '1 : quot;
    div_hi   = div_zero ? a_q : rem;
  end

  // Sequencer state, post-reset ready enable and request capture.
  always_ff @(posedge iClk or negedge nRst) begin
    if (!nRst) begin
      state_q  <= S_IDLE;
      live_q   <= 1'b0;
      op_q     <= '0;
      ra_q     <= '0;
      rb_q     <= '0;
      rc_q     <= '0;
      immsel_q <= 1'b0;
      imm_q    <= '0;
    end else begin
      state_q <= state_d;
      live_q  <= 1'b1;
      if (accept) begin
        op_q     <= iOp;
        ra_q     <= iRa;
        rb_q     <= iRb;
        rc_q     <= iRc;
        immsel_q <= iImmSel;
        imm_q    <= iImm;
      end
    end
  end

  // Operand latching, iterative MUL/DIV steps and end-of-WB state update.
  always_ff @(posedge iClk or negedge nRst) begin
    if (!nRst) begin
      a_q     <= '0;
      b_q     <= '0;
      wk_hi_q <= '0;
      wk_lo_q <= '0;
      mag_q   <= '0;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      zero_q  <= 1'b0;
      neg_q   <= 1'b0;
      dz_q    <= 1'b0;
      for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
    end else begin
      case (state_q)
        S_READ: begin
          a_q     <= opa;
          b_q     <= opb;
          wk_hi_q <= '0;
          cnt_q   <= '0;
          // MUL shifts the multiplier (B) out of wk_lo; DIV shifts the dividend (A).
          if (op_q == OP_MUL) begin
            wk_lo_q <= magnitude(opb);
            mag_q   <= magnitude(opa);
          end else begin
            wk_lo_q <= magnitude(opa);
            mag_q   <= magnitude(opb);
          end
        end
        S_EXEC: begin
          if (is_long) begin
            cnt_q <= cnt_q + SW'(1);
            if (op_q == OP_MUL) begin
              wk_hi_q <= mul_sum[WIDTH:1];
              wk_lo_q <= {mul_sum[0], wk_lo_q[WIDTH-1:1]};
            end else begin
              wk_hi_q <= div_ge ? div_diff : div_rs[WIDTH-1:0];
              wk_lo_q <= {wk_lo_q[WIDTH-2:0], div_ge};
            end
          end
        end
        S_WB: begin
          if (op_q == OP_MUL) begin
            hi_q   <= prod[2*WIDTH-1:WIDTH];
            lo_q   <= prod[WIDTH-1:0];
            zero_q <= (prod == '0);
            neg_q  <= prod[2*WIDTH-1];
          end else if (op_q == OP_DIV) begin
            hi_q   <= div_hi;
            lo_q   <= div_lo;
            zero_q <= (div_lo == '0);
            neg_q  <= div_lo[WIDTH-1];
            dz_q   <= div_zero;
          end else if (op_q != OP_NOP) begin
            zero_q <= (alu == '0);
            neg_q  <= alu[WIDTH-1];
            if (!(ZERO_R0 && (rc_q == '0))) rf_q[rc_q] <= alu;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dp_exec_core.sv
// tb_dp_exec_core: directed scenarios plus randomized ops against a
// plain-arithmetic reference model of the register file, HI/LO and flags.
module tb_dp_exec_core;

  logic        iClk = 1'b0;
  logic        nRst = 1'b1;
  logic        iReq_valid = 1'b0;
  logic        oReq_ready;
  logic [3:0]  iOp = '0;
  logic [3:0]  iRa = '0, iRb = '0, iRc = '0;
  logic        iImmSel = 1'b0;
  logic [31:0] iImm = '0;
  logic        oDone, oZero, oNeg, oDivZero;
  logic [3:0]  iDbg_addr = '0;
  logic [31:0] oDbg_data;
  logic [1:0]  oDbg_state;

  int n_cmp = 0;
  int n_fail = 0;

  logic [31:0] m_rf [16];
  logic [31:0] m_hi, m_lo;
  logic        m_zero, m_neg, m_dz;

  dp_exec_core #(.WIDTH(32), .NREGS(16), .ZERO_R0(1'b1)) dut (
    .iClk(iClk), .nRst(nRst), .iReq_valid(iReq_valid), .oReq_ready(oReq_ready),
    .iOp(iOp), .iRa(iRa), .iRb(iRb), .iRc(iRc), .iImmSel(iImmSel), .iImm(iImm),
    .oDone(oDone), .oZero(oZero), .oNeg(oNeg), .oDivZero(oDivZero),
    .iDbg_addr(iDbg_addr), .oDbg_data(oDbg_data), .oDbg_state(oDbg_state)
  );

  // Clock and watchdog
  always #5 iClk = ~iClk;

  initial begin
    #500000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $fatal(1);
  end

  // Reference model
  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_rf[i] = '0;
    m_hi = '0; m_lo = '0; m_zero = 1'b0; m_neg = 1'b0; m_dz = 1'b0;
  endtask

  task automatic model_apply(input logic [3:0] op, input logic [3:0] ra, input logic [3:0] rb,
                             input logic [3:0] rc, input logic immsel, input logic [31:0] imm);
    logic [31:0] a, b, r;
    longint sa, sb, p, q, rm;
    int sh;
    bit wr;
    a  = (ra == 0) ? 32'd0 : m_rf[ra];
    b  = immsel ? imm : ((rb == 0) ? 32'd0 : m_rf[rb]);
    sh = int'(b % 32);
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    wr = 1'b1;
    r  = '0;
    case (op)
      4'h0: r = a + b;
      4'h1: r = a - b;
      4'h2: r = a & b;
      4'h3: r = a | b;
      4'h4: r = a >> sh;
      4'h5: begin p = sa >>> sh; r = p[31:0]; end
      4'h6: r = a << sh;
      4'h7: begin r = a; repeat (sh) r = {r[0], r[31:1]}; end
      4'h8: begin r = a; repeat (sh) r = {r[30:0], r[31]}; end
      4'h9: begin
        p = sa * sb;
        m_hi = p[63:32]; m_lo = p[31:0];
        m_zero = (p == 0); m_neg = p[63];
        wr = 1'b0;
      end
      4'hA: begin
        if (b == 0) begin
          m_lo = 32'hFFFF_FFFF; m_hi = a; m_dz = 1'b1;
        end else begin
          q = sa / sb; rm = sa % sb;
          m_lo = q[31:0]; m_hi = rm[31:0]; m_dz = 1'b0;
        end
        m_zero = (m_lo == 0); m_neg = m_lo[31];
        wr = 1'b0;
      end
      4'hB: r = -a;
      4'hC: r = ~a;
      4'hD: r = m_hi;
      4'hE: r = m_lo;
      default: wr = 1'b0;
    endcase
    if (wr) begin
      m_zero = (r == 0);
      m_neg  = r[31];
      if (rc != 0) m_rf[rc] = r;
    end
  endtask

  // Driver: issue one request, measure oDone and ready-return cycle relative
  // to the accept edge N (cycle N+k is the k-th cycle after that edge).
  task automatic issue(input logic [3:0] op, input logic [3:0] ra, input logic [3:0] rb,
                       input logic [3:0] rc, input logic immsel, input logic [31:0] imm,
                       output int done_rel, output int ready_rel);
    int t;
    done_rel = -1;
    ready_rel = -1;
    t = 0;
    @(negedge iClk);
    while (oReq_ready !== 1'b1 && t < 100) begin
      @(negedge iClk);
      t++;
    end
    if (oReq_ready !== 1'b1) begin
      n_cmp++; n_fail++;
      $display("FAIL issue_wait_ready: ready=%b required 1 within 100 cycles", oReq_ready);
      return;
    end
    iOp = op; iRa = ra; iRb = rb; iRc = rc; iImmSel = immsel; iImm = imm;
    iReq_valid = 1'b1;
    @(posedge iClk);
    #1;
    iReq_valid = 1'b0;
    iOp = 4'($urandom); iRa = 4'($urandom); iRb = 4'($urandom); iRc = 4'($urandom);
    iImmSel = 1'($urandom); iImm = $urandom;
    for (int k = 1; k <= 100; k++) begin
      @(negedge iClk);
      if (oDone === 1'b1 && done_rel < 0) done_rel = k;
      if (oReq_ready === 1'b1) begin
        ready_rel = k;
        break;
      end
    end
    if (ready_rel < 0) begin
      n_cmp++; n_fail++;
      $display("FAIL issue_ready_return: ready never returned within 100 cycles");
    end
  endtask

  task automatic run_op(input logic [3:0] op, input logic [3:0] ra, input logic [3:0] rb,
                        input logic [3:0] rc, input logic immsel, input logic [31:0] imm,
                        output int done_rel, output int ready_rel);
    issue(op, ra, rb, rc, immsel, imm, done_rel, ready_rel);
    model_apply(op, ra, rb, rc, immsel, imm);
  endtask

  task automatic read_reg(input logic [3:0] addr, output logic [31:0] data);
    iDbg_addr = addr;
    #1;
    data = oDbg_data;
  endtask

  task automatic test_reset();
    logic [31:0] v;
    #1 nRst = 1'b0;
    #1;
    model_reset();
    n_cmp++; if (oReq_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready: got %b want 0", oReq_ready); end
    n_cmp++; if (oDone !== 1'b0) begin n_fail++; $display("FAIL rst_done: got %b want 0", oDone); end
    n_cmp++; if ({oZero, oNeg, oDivZero} !== 3'b000) begin n_fail++; $display("FAIL rst_flags: got %b want 000", {oZero, oNeg, oDivZero}); end
    for (int i = 0; i < 16; i++) begin
      read_reg(4'(i), v);
      n_cmp++; if (v !== 32'd0) begin n_fail++; $display("FAIL rst_reg%0d: got %h want 0", i, v); end
    end
    repeat (2) @(posedge iClk);
    #1;
    n_cmp++; if (oReq_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready_held: got %b want 0", oReq_ready); end
    @(negedge iClk);
    nRst = 1'b1;
    #1;
    n_cmp++; if (oReq_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready_before_edge: got %b want 0", oReq_ready); end
    @(posedge iClk);
    #1;
    n_cmp++; if (oReq_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready_after_edge: got %b want 1", oReq_ready); end
  endtask

  task automatic test_add_timing();
    int d, r;
    logic [31:0] v;
    run_op(4'h0, 4'd0, 4'd0, 4'd1, 1'b1, 32'd5, d, r);
    n_cmp++; if (d !== 3) begin n_fail++; $display("FAIL add_done_cycle: got N+%0d want N+3", d); end
    n_cmp++; if (r !== 4) begin n_fail++; $display("FAIL add_ready_cycle: got N+%0d want N+4", r); end
    read_reg(4'd1, v);
    n_cmp++; if (v !== 32'd5) begin n_fail++; $display("FAIL add_r1: got %h want 5", v); end
    n_cmp++; if (oZero !== 1'b0) begin n_fail++; $display("FAIL add_zero: got %b want 0", oZero); end
  endtask

  task automatic test_mul();
    int d, r;
    logic [31:0] v;
    run_op(4'h0, 4'd0, 4'd0, 4'd1, 1'b1, 32'hFFFF_FFFD, d, r);
    run_op(4'h0, 4'd0, 4'd0, 4'd2, 1'b1, 32'd7, d, r);
    run_op(4'h9, 4'd1, 4'd2, 4'd5, 1'b0, 32'd0, d, r);
    n_cmp++; if (d !== 34) begin n_fail++; $display("FAIL mul_done_cycle: got N+%0d want N+34", d); end
    n_cmp++; if (r !== 35) begin n_fail++; $display("FAIL mul_ready_cycle: got N+%0d want N+35", r); end
    n_cmp++; if (oNeg !== 1'b1 || oZero !== 1'b0) begin n_fail++; $display("FAIL mul_flags: got neg=%b zero=%b want 1 0", oNeg, oZero); end
    read_reg(4'd5, v);
    n_cmp++; if (v !== 32'd0) begin n_fail++; $display("FAIL mul_gpr_untouched: got %h want 0", v); end
    run_op(4'hE, 4'd0, 4'd0, 4'd3, 1'b0, 32'd0, d, r);
    read_reg(4'd3, v);
    n_cmp++; if (v !== 32'hFFFF_FFEB) begin n_fail++; $display("FAIL mul_lo: got %h want ffffffeb", v); end
    run_op(4'hD, 4'd0, 4'd0, 4'd4, 1'b0, 32'd0, d, r);
    read_reg(4'd4, v);
    n_cmp++; if (v !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL mul_hi: got %h want ffffffff", v); end
  endtask

  task automatic test_div();
    int d, r;
    logic [31:0] v;
    run_op(4'h0, 4'd0, 4'd0, 4'd5, 1'b1, 32'd7, d, r);
    run_op(4'hA, 4'd5, 4'd0, 4'd0, 1'b1, 32'hFFFF_FFFE, d, r);
    n_cmp++; if (d !== 34) begin n_fail++; $display("FAIL div_done_cycle: got N+%0d want N+34", d); end
    n_cmp++; if (oDivZero !== 1'b0) begin n_fail++; $display("FAIL div_dz_clear: got %b want 0", oDivZero); end
    run_op(4'hE, 4'd0, 4'd0, 4'd6, 1'b0, 32'd0, d, r);
    run_op(4'hD, 4'd0, 4'd0, 4'd7, 1'b0, 32'd0, d, r);
    read_reg(4'd6, v);
    n_cmp++; if (v !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL div_quot: got %h want fffffffd", v); end
    read_reg(4'd7, v);
    n_cmp++; if (v !== 32'd1) begin n_fail++; $display("FAIL div_rem: got %h want 1", v); end
    run_op(4'h0, 4'd0, 4'd0, 4'd8, 1'b1, 32'd9, d, r);
    run_op(4'hA, 4'd8, 4'd0, 4'd0, 1'b1, 32'd0, d, r);
    n_cmp++; if (d !== 34) begin n_fail++; $display("FAIL div0_done_cycle: got N+%0d want N+34", d); end
    n_cmp++; if (oDivZero !== 1'b1) begin n_fail++; $display("FAIL div0_dz: got %b want 1", oDivZero); end
    run_op(4'hE, 4'd0, 4'd0, 4'd6, 1'b0, 32'd0, d, r);
    run_op(4'hD, 4'd0, 4'd0, 4'd7, 1'b0, 32'd0, d, r);
    n_cmp++; if (oDivZero !== 1'b1) begin n_fail++; $display("FAIL div0_dz_sticky: got %b want 1", oDivZero); end
    read_reg(4'd6, v);
    n_cmp++; if (v !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL div0_lo: got %h want ffffffff", v); end
    read_reg(4'd7, v);
    n_cmp++; if (v !== 32'd9) begin n_fail++; $display("FAIL div0_hi: got %h want 9", v); end
    run_op(4'h0, 4'd0, 4'd0, 4'd9, 1'b1, 32'h8000_0000, d, r);
    run_op(4'hA, 4'd9, 4'd0, 4'd0, 1'b1, 32'hFFFF_FFFF, d, r);
    n_cmp++; if (oDivZero !== 1'b0) begin n_fail++; $display("FAIL divmin_dz: got %b want 0", oDivZero); end
    run_op(4'hE, 4'd0, 4'd0, 4'd6, 1'b0, 32'd0, d, r);
    run_op(4'hD, 4'd0, 4'd0, 4'd7, 1'b0, 32'd0, d, r);
    read_reg(4'd6, v);
    n_cmp++; if (v !== 32'h8000_0000) begin n_fail++; $display("FAIL divmin_lo: got %h want 80000000", v); end
    read_reg(4'd7, v);
    n_cmp++; if (v !== 32'd0) begin n_fail++; $display("FAIL divmin_hi: got %h want 0", v); end
  endtask

  task automatic test_back_to_back();
    int d, r, second_rel, t;
    logic [31:0] v;
    second_rel = -1;
    t = 0;
    @(negedge iClk);
    while (oReq_ready !== 1'b1 && t < 100) begin @(negedge iClk); t++; end
    iOp = 4'h9; iRa = 4'd1; iRb = 4'd2; iRc = 4'd0; iImmSel = 1'b0; iImm = '0;
    iReq_valid = 1'b1;
    @(posedge iClk);
    #1;
    model_apply(4'h9, 4'd1, 4'd2, 4'd0, 1'b0, 32'd0);
    iOp = 4'h0; iRa = 4'd0; iRc = 4'd10; iImmSel = 1'b1; iImm = 32'd77;
    for (int k = 1; k <= 60; k++) begin
      @(negedge iClk);
      if (oReq_ready === 1'b1) begin
        second_rel = k;
        break;
      end
    end
    n_cmp++; if (second_rel !== 35) begin n_fail++; $display("FAIL hold_ready_return: got N+%0d want N+35", second_rel); end
    if (second_rel > 0) begin
      @(posedge iClk);
      #1;
      model_apply(4'h0, 4'd0, 4'd0, 4'd10, 1'b1, 32'd77);
    end
    iReq_valid = 1'b0;
    run_op(4'hE, 4'd0, 4'd0, 4'd11, 1'b0, 32'd0, d, r);
    read_reg(4'd10, v);
    n_cmp++; if (v !== 32'd77) begin n_fail++; $display("FAIL hold_next_op: got %h want 4d", v); end
    read_reg(4'd11, v);
    n_cmp++; if (v !== m_lo) begin n_fail++; $display("FAIL hold_mul_lo: got %h want %h", v, m_lo); end
  endtask

  task automatic test_reset_mid_op();
    int d, r, t;
    bit done_seen;
    logic [31:0] v;
    done_seen = 1'b0;
    t = 0;
    @(negedge iClk);
    while (oReq_ready !== 1'b1 && t < 100) begin @(negedge iClk); t++; end
    iOp = 4'h9; iRa = 4'd1; iRb = 4'd2; iRc = 4'd0; iImmSel = 1'b0;
    iReq_valid = 1'b1;
    @(posedge iClk);
    #1;
    iReq_valid = 1'b0;
    repeat (10) begin
      @(negedge iClk);
      if (oDone === 1'b1) done_seen = 1'b1;
    end
    nRst = 1'b0;
    #1;
    model_reset();
    n_cmp++; if (oReq_ready !== 1'b0) begin n_fail++; $display("FAIL midrst_ready: got %b want 0", oReq_ready); end
    n_cmp++; if ({oZero, oNeg, oDivZero} !== 3'b000) begin n_fail++; $display("FAIL midrst_flags: got %b want 000", {oZero, oNeg, oDivZero}); end
    for (int i = 0; i < 16; i++) begin
      read_reg(4'(i), v);
      n_cmp++; if (v !== 32'd0) begin n_fail++; $display("FAIL midrst_reg%0d: got %h want 0", i, v); end
    end
    repeat (3) begin
      @(negedge iClk);
      if (oDone === 1'b1) done_seen = 1'b1;
    end
    nRst = 1'b1;
    #1;
    n_cmp++; if (oReq_ready !== 1'b0) begin n_fail++; $display("FAIL midrst_ready_before_edge: got %b want 0", oReq_ready); end
    @(posedge iClk);
    #1;
    n_cmp++; if (oReq_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_ready_after_edge: got %b want 1", oReq_ready); end
    repeat (40) begin
      @(negedge iClk);
      if (oDone === 1'b1) done_seen = 1'b1;
    end
    n_cmp++; if (done_seen !== 1'b0) begin n_fail++; $display("FAIL midrst_no_done: got done seen=%b want 0", done_seen); end
    run_op(4'hD, 4'd0, 4'd0, 4'd1, 1'b0, 32'd0, d, r);
    run_op(4'hE, 4'd0, 4'd0, 4'd2, 1'b0, 32'd0, d, r);
    read_reg(4'd1, v);
    n_cmp++; if (v !== 32'd0) begin n_fail++; $display("FAIL midrst_hi: got %h want 0", v); end
    read_reg(4'd2, v);
    n_cmp++; if (v !== 32'd0) begin n_fail++; $display("FAIL midrst_lo: got %h want 0", v); end
    n_cmp++; if (oZero !== 1'b1) begin n_fail++; $display("FAIL midrst_mflo_zero: got %b want 1", oZero); end
  endtask

  task automatic test_boundaries();
    int d, r;
    logic [31:0] v;
    run_op(4'h0, 4'd0, 4'd0, 4'd0, 1'b1, 32'h8000_0000, d, r);
    read_reg(4'd0, v);
    n_cmp++; if (v !== 32'd0) begin n_fail++; $display("FAIL r0_discard: got %h want 0", v); end
    n_cmp++; if (oNeg !== 1'b1 || oZero !== 1'b0) begin n_fail++; $display("FAIL r0_flags: got neg=%b zero=%b want 1 0", oNeg, oZero); end
    run_op(4'h0, 4'd0, 4'd0, 4'd1, 1'b1, 32'd3, d, r);
    run_op(4'h6, 4'd1, 4'd0, 4'd2, 1'b1, 32'd33, d, r);
    read_reg(4'd2, v);
    n_cmp++; if (v !== 32'd6) begin n_fail++; $display("FAIL shl_mod: got %h want 6", v); end
    run_op(4'h0, 4'd0, 4'd0, 4'd3, 1'b1, 32'd1, d, r);
    run_op(4'h7, 4'd3, 4'd0, 4'd4, 1'b1, 32'd1, d, r);
    read_reg(4'd4, v);
    n_cmp++; if (v !== 32'h8000_0000) begin n_fail++; $display("FAIL ror: got %h want 80000000", v); end
    run_op(4'hF, 4'd4, 4'd0, 4'd4, 1'b1, 32'd0, d, r);
    n_cmp++; if (d !== 3) begin n_fail++; $display("FAIL nop_done_cycle: got N+%0d want N+3", d); end
    n_cmp++; if (oNeg !== 1'b1 || oZero !== 1'b0) begin n_fail++; $display("FAIL nop_flags_hold: got neg=%b zero=%b want 1 0", oNeg, oZero); end
    run_op(4'h5, 4'd4, 4'd0, 4'd5, 1'b1, 32'd4, d, r);
    read_reg(4'd5, v);
    n_cmp++; if (v !== 32'hF800_0000) begin n_fail++; $display("FAIL shra: got %h want f8000000", v); end
    run_op(4'h8, 4'd4, 4'd0, 4'd6, 1'b1, 32'd1, d, r);
    read_reg(4'd6, v);
    n_cmp++; if (v !== 32'd1) begin n_fail++; $display("FAIL rol: got %h want 1", v); end
  endtask

  task automatic test_random();
    int d, r, want_done;
    logic [3:0] op, ra, rb, rc;
    logic immsel;
    logic [31:0] imm, v;
    for (int n = 0; n < 80; n++) begin
      op = 4'($urandom_range(0, 15));
      ra = 4'($urandom_range(0, 15));
      rb = 4'($urandom_range(0, 15));
      rc = 4'($urandom_range(0, 15));
      immsel = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0: imm = $urandom;
        1: imm = 32'($urandom_range(0, 40));
        2: imm = 32'd0;
        default: imm = 32'hFFFF_FFFF - 32'($urandom_range(0, 5));
      endcase
      run_op(op, ra, rb, rc, immsel, imm, d, r);
      want_done = (op == 4'h9 || op == 4'hA) ? 34 : 3;
      n_cmp++; if (d !== want_done || r !== want_done + 1) begin n_fail++; $display("FAIL rnd%0d_timing op=%h: got done N+%0d ready N+%0d want N+%0d N+%0d", n, op, d, r, want_done, want_done + 1); end
      n_cmp++; if ({oZero, oNeg, oDivZero} !== {m_zero, m_neg, m_dz}) begin n_fail++; $display("FAIL rnd%0d_flags op=%h: got %b want %b", n, op, {oZero, oNeg, oDivZero}, {m_zero, m_neg, m_dz}); end
      read_reg(rc, v);
      n_cmp++; if (v !== m_rf[rc]) begin n_fail++; $display("FAIL rnd%0d_dest op=%h r%0d: got %h want %h", n, op, rc, v, m_rf[rc]); end
    end
    for (int i = 0; i < 16; i++) begin
      read_reg(4'(i), v);
      n_cmp++; if (v !== m_rf[i]) begin n_fail++; $display("FAIL rnd_final_reg%0d: got %h want %h", i, v, m_rf[i]); end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_add_timing();
    test_mul();
    test_div();
    test_back_to_back();
    test_reset_mid_op();
    test_boundaries();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
